// File: rtl/dual_port_ram_wb.sv
// True dual-port word RAM with two Wishbone-classic-style slave ports, byte lanes,
// optional output register and deterministic same-address collision resolution.
module dual_port_ram_wb #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int OUT_REG   = 0,
  parameter int RW_MODE   = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                a_stb_i,
  input  logic                a_we_i,
  input  logic [ADDR_W-1:0]   a_adr_i,
  input  logic [DATA_W/8-1:0] a_sel_i,
  input  logic [DATA_W-1:0]   a_dat_i,
  output logic [DATA_W-1:0]   a_dat_o,
  output logic                a_ack_o,
  input  logic                b_stb_i,
  input  logic                b_we_i,
  input  logic [ADDR_W-1:0]   b_adr_i,
  input  logic [DATA_W/8-1:0] b_sel_i,
  input  logic [DATA_W-1:0]   b_dat_i,
  output logic [DATA_W-1:0]   b_dat_o,
  output logic                b_ack_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  state_e a_state_q, a_state_d, b_state_q, b_state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_dat_q, b_dat_q, a_pipe_q, b_pipe_q;
  logic [DATA_W-1:0] a_old, b_old, a_new, b_new, a_rd, b_rd;
  logic a_acc, b_acc, a_wr, b_wr, same_adr;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] dat,
                                               input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < SEL_W; i++)
      if (sel[i]) r[8*i +: 8] = dat[8*i +: 8];
    return r;
  endfunction

  generate
    if (INIT_ZERO != 0) begin : g_init
      initial for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
    end
  endgenerate

  assign a_acc    = (a_state_q == IDLE) && a_stb_i;
  assign b_acc    = (b_state_q == IDLE) && b_stb_i;
  assign a_wr     = a_acc && a_we_i;
  assign b_wr     = b_acc && b_we_i;
  assign same_adr = (a_adr_i == b_adr_i);

  // B's lanes go in first so that A's lanes override them on a shared address
  always_comb begin
    a_old = mem_q[a_adr_i];
    b_old = mem_q[b_adr_i];
    a_new = a_old;
    if (b_wr && same_adr) a_new = merge(a_new, b_dat_i, b_sel_i);
    if (a_wr)             a_new = merge(a_new, a_dat_i, a_sel_i);
    b_new = b_old;
    if (b_wr)             b_new = merge(b_new, b_dat_i, b_sel_i);
    if (a_wr && same_adr) b_new = merge(b_new, a_dat_i, a_sel_i);
    a_rd = (a_we_i || (RW_MODE != 0)) ? a_new : a_old;
    b_rd = (b_we_i || (RW_MODE != 0)) ? b_new : b_old;
  end

  always_ff @(posedge clk_i) begin
    if (a_wr) mem_q[a_adr_i] <= a_new;
    if (b_wr) mem_q[b_adr_i] <= b_new;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_state_q <= IDLE;
      b_state_q <= IDLE;
    end else begin
      a_state_q <= a_state_d;
      b_state_q <= b_state_d;
    end
  end

  always_comb begin
    a_state_d = a_state_q;
    b_state_d = b_state_q;
    case (a_state_q)
      IDLE:    if (a_stb_i) a_state_d = (OUT_REG != 0) ? BUSY : ACK;
      BUSY:    a_state_d = ACK;
      default: a_state_d = IDLE;
    endcase
    case (b_state_q)
      IDLE:    if (b_stb_i) b_state_d = (OUT_REG != 0) ? BUSY : ACK;
      BUSY:    b_state_d = ACK;
      default: b_state_d = IDLE;
    endcase
  end

  // With the output register, the array word parks in pipe_q until the BUSY cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_dat_q  <= '0;
      b_dat_q  <= '0;
      a_pipe_q <= '0;
      b_pipe_q <= '0;
    end else begin
      if (a_acc) begin
        if (OUT_REG != 0) a_pipe_q <= a_rd;
        else              a_dat_q  <= a_rd;
      end
      if (b_acc) begin
        if (OUT_REG != 0) b_pipe_q <= b_rd;
        else              b_dat_q  <= b_rd;
      end
      if ((OUT_REG != 0) && (a_state_q == BUSY)) a_dat_q <= a_pipe_q;
      if ((OUT_REG != 0) && (b_state_q == BUSY)) b_dat_q <= b_pipe_q;
    end
  end

  always_comb begin
    a_ack_o = (a_state_q == ACK);
    b_ack_o = (b_state_q == ACK);
    a_dat_o = a_dat_q;
    b_dat_o = b_dat_q;
  end

endmodule

// File: tb/tb_dual_port_ram_wb.sv
// Directed bench: dut0 (OUT_REG=0, read-first) and dut1 (OUT_REG=1, write-first)
// share one stimulus stream; accesses are single-edge strobes so both accept together.
module tb_dual_port_ram_wb;

  logic clock, rstN;
  logic aStb, aWe, bStb, bWe;
  logic [11:0] aAdr, bAdr;
  logic [3:0] aSel, bSel;
  logic [31:0] aDat, bDat;
  logic [31:0] aDat0, bDat0, aDat1, bDat1;
  logic aAck0, bAck0, aAck1, bAck1;
  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    string name;
    logic aStb, aWe; logic [11:0] aAdr; logic [3:0] aSel; logic [31:0] aDat;
    logic bStb, bWe; logic [11:0] bAdr; logic [3:0] bSel; logic [31:0] bDat;
    logic [31:0] expA0, expB0, expA1, expB1;
  } vec_t;

  vec_t vecs[12];

  dual_port_ram_wb #(.ADDR_W(12), .DATA_W(32), .OUT_REG(0), .RW_MODE(0), .INIT_ZERO(1)) dut0 (
    .clk_i(clock), .rst_ni(rstN),
    .a_stb_i(aStb), .a_we_i(aWe), .a_adr_i(aAdr), .a_sel_i(aSel), .a_dat_i(aDat),
    .a_dat_o(aDat0), .a_ack_o(aAck0),
    .b_stb_i(bStb), .b_we_i(bWe), .b_adr_i(bAdr), .b_sel_i(bSel), .b_dat_i(bDat),
    .b_dat_o(bDat0), .b_ack_o(bAck0)
  );

  dual_port_ram_wb #(.ADDR_W(12), .DATA_W(32), .OUT_REG(1), .RW_MODE(1), .INIT_ZERO(1)) dut1 (
    .clk_i(clock), .rst_ni(rstN),
    .a_stb_i(aStb), .a_we_i(aWe), .a_adr_i(aAdr), .a_sel_i(aSel), .a_dat_i(aDat),
    .a_dat_o(aDat1), .a_ack_o(aAck1),
    .b_stb_i(bStb), .b_we_i(bWe), .b_adr_i(bAdr), .b_sel_i(bSel), .b_dat_i(bDat),
    .b_dat_o(bDat1), .b_ack_o(bAck1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Strobe for exactly one edge, then scramble inputs to prove they were latched at accept
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    aStb = v.aStb; aWe = v.aWe; aAdr = v.aAdr; aSel = v.aSel; aDat = v.aDat;
    bStb = v.bStb; bWe = v.bWe; bAdr = v.bAdr; bSel = v.bSel; bDat = v.bDat;
    @(posedge clock);
    #1;
    aStb = 1'b0; bStb = 1'b0;
    aAdr = ~v.aAdr; bAdr = ~v.bAdr; aDat = ~v.aDat; bDat = ~v.bDat;
    aSel = 4'hF; bSel = 4'hF; aWe = ~v.aWe; bWe = ~v.bWe;
    @(negedge clock);
    if (v.aStb) begin
      checkOutput({v.name, ".ack0A"}, {31'd0, aAck0}, 32'd1);
      checkOutput({v.name, ".dat0A"}, aDat0, v.expA0);
      checkOutput({v.name, ".early1A"}, {31'd0, aAck1}, 32'd0);
    end
    if (v.bStb) begin
      checkOutput({v.name, ".ack0B"}, {31'd0, bAck0}, 32'd1);
      checkOutput({v.name, ".dat0B"}, bDat0, v.expB0);
      checkOutput({v.name, ".early1B"}, {31'd0, bAck1}, 32'd0);
    end
    aWe = 1'b0; bWe = 1'b0;
    @(negedge clock);
    if (v.aStb) begin
      checkOutput({v.name, ".ack1A"}, {31'd0, aAck1}, 32'd1);
      checkOutput({v.name, ".dat1A"}, aDat1, v.expA1);
      checkOutput({v.name, ".late0A"}, {31'd0, aAck0}, 32'd0);
    end
    if (v.bStb) begin
      checkOutput({v.name, ".ack1B"}, {31'd0, bAck1}, 32'd1);
      checkOutput({v.name, ".dat1B"}, bDat1, v.expB1);
      checkOutput({v.name, ".late0B"}, {31'd0, bAck0}, 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    logic [10:0] mask0, mask1;

    vecs[0]  = '{"rdZero", 1,0,12'd0,4'h0,32'h0,          0,0,12'd0,4'h0,32'h0,
                 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{"wrFull", 1,1,12'd5,4'hF,32'h11223344,   0,0,12'd0,4'h0,32'h0,
                 32'h11223344, 32'h0, 32'h11223344, 32'h0};
    vecs[2]  = '{"wrMask", 1,1,12'd5,4'h5,32'hAABBCCDD,   0,0,12'd0,4'h0,32'h0,
                 32'h11BB33DD, 32'h0, 32'h11BB33DD, 32'h0};
    vecs[3]  = '{"rdB5",   0,0,12'd0,4'h0,32'h0,          1,0,12'd5,4'h0,32'h0,
                 32'h0, 32'h11BB33DD, 32'h0, 32'h11BB33DD};
    vecs[4]  = '{"wwColl", 1,1,12'd9,4'h3,32'h000000AA,   1,1,12'd9,4'h6,32'hBBBBBBBB,
                 32'h00BB00AA, 32'h00BB00AA, 32'h00BB00AA, 32'h00BB00AA};
    vecs[5]  = '{"wr3",    1,1,12'd3,4'hF,32'h12345678,   0,0,12'd0,4'h0,32'h0,
                 32'h12345678, 32'h0, 32'h12345678, 32'h0};
    vecs[6]  = '{"rwColl", 1,0,12'd3,4'h0,32'h0,          1,1,12'd3,4'hF,32'hCAFEF00D,
                 32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[7]  = '{"rdB3",   0,0,12'd0,4'h0,32'h0,          1,0,12'd3,4'h0,32'h0,
                 32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D};
    vecs[8]  = '{"wrSel0", 1,1,12'd5,4'h0,32'hFFFFFFFF,   0,0,12'd0,4'h0,32'h0,
                 32'h11BB33DD, 32'h0, 32'h11BB33DD, 32'h0};
    vecs[9]  = '{"indep",  1,1,12'hFFF,4'hF,32'hDEADBEEF, 1,0,12'd5,4'h0,32'h0,
                 32'hDEADBEEF, 32'h11BB33DD, 32'hDEADBEEF, 32'h11BB33DD};
    vecs[10] = '{"rwTop",  1,0,12'hFFF,4'h0,32'h0,        1,1,12'hFFF,4'h8,32'h77000000,
                 32'hDEADBEEF, 32'h77ADBEEF, 32'h77ADBEEF, 32'h77ADBEEF};
    vecs[11] = '{"wrB0",   1,0,12'd1,4'h0,32'h0,          1,1,12'd0,4'h1,32'h00000055,
                 32'h0, 32'h00000055, 32'h0, 32'h00000055};

    aStb = 0; aWe = 0; aAdr = 0; aSel = 0; aDat = 0;
    bStb = 0; bWe = 0; bAdr = 0; bSel = 0; bDat = 0;
    rstN = 1'b1;
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst.ack0A", {31'd0, aAck0}, 32'd0);
    checkOutput("rst.ack1B", {31'd0, bAck1}, 32'd0);
    checkOutput("rst.dat0A", aDat0, 32'd0);
    checkOutput("rst.dat1B", bDat1, 32'd0);
    repeat (2) @(negedge clock);
    rstN = 1'b1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Held strobe: edges 1..4 see stb high
    mask0 = '0; mask1 = '0;
    @(negedge clock);
    aStb = 1'b1; aWe = 1'b0; aAdr = 12'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      if (c == 4) begin
        #1 aStb = 1'b0;
      end
      @(negedge clock);
      mask0[c] = aAck0;
      mask1[c] = aAck1;
    end
    checkOutput("held.mask0", {21'd0, mask0}, 32'b00000001010);
    checkOutput("held.mask1", {21'd0, mask1}, 32'b00000100100);
    checkOutput("held.dat0", aDat0, 32'h0);

    // Reset in the middle of an access: dut0 is in ACK, dut1 in BUSY
    @(negedge clock);
    aStb = 1'b1; aWe = 1'b0; aAdr = 12'd5;
    @(posedge clock);
    #1 aStb = 1'b0;
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRst.ack0A", {31'd0, aAck0}, 32'd0);
    checkOutput("midRst.dat0A", aDat0, 32'd0);
    checkOutput("midRst.dat1B", bDat1, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (c == 1) rstN = 1'b1;
      checkOutput("midRst.noAck1A", {31'd0, aAck1}, 32'd0);
    end

    v = '{"postRst", 1,0,12'd9,4'h0,32'h0, 1,0,12'd0,4'h0,32'h0,
          32'h00BB00AA, 32'h00000055, 32'h00BB00AA, 32'h00000055};
    applyStimulus(v);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
